data_mem_ctrl: RTL and testbench

Parametrised, byte-addressable RV32 data memory with a valid/ready request handshake, a configurable fixed access latency, and one outstanding request. It supports all RV32I load/store widths with little-endian layout and sign/zero extension. Misaligned, out-of-range and illegal-func3 accesses are flagged on an error response instead of touching memory. It sits in the MEM stage of the pipelined core; the hazard unit stalls on req_ready/resp_valid.

---
 rtl/data_mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressable RV32 data memory with a valid/ready request port, fixed access
// latency and a single outstanding request; bad accesses return an error response.
module data_mem_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int BYTES = 4 * DEPTH_WORDS;
  localparam int IDX_W = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        func3_q, func3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [7:0]        mem [BYTES];

  logic [31:0]       a32, last_byte, word;
  logic [IDX_W-1:0]  i0, i1, i2, i3;
  logic              misaligned, out_of_range, bad_func3, req_err, access;
  logic [3:0]        be;

  // Sign or zero extension of the addressed bytes according to the load type.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] w);
    logic signed [31:0] s;
    case (f3)
      3'd0:    s = 32'(signed'(w[7:0]));
      3'd1:    s = 32'(signed'(w[15:0]));
      3'd4:    s = {24'd0, w[7:0]};
      3'd5:    s = {16'd0, w[15:0]};
      default: s = w;
    endcase
    return s;
  endfunction

  always_comb begin
    a32 = 32'(addr_q);
    case (func3_q[1:0])
      2'd0:    last_byte = a32;
      2'd1:    last_byte = a32 + 32'd1;
      default: last_byte = a32 + 32'd3;
    endcase
    out_of_range = last_byte >= 32'(BYTES);
    misaligned   = (func3_q[1:0] == 2'd1 && addr_q[0]) ||
                   (func3_q[1:0] == 2'd2 && addr_q[1:0] != 2'd0);
    bad_func3    = we_q ? (func3_q > 3'd2)
                        : (func3_q == 3'd3 || func3_q[2:1] == 2'b11);
    req_err      = misaligned | out_of_range | bad_func3;
    access       = (state_q == WAIT) && (cnt_q == 4'd0);

    // Index wrap is harmless: erroneous requests never use the data.
    i0   = IDX_W'(a32);
    i1   = IDX_W'(a32 + 32'd1);
    i2   = IDX_W'(a32 + 32'd2);
    i3   = IDX_W'(a32 + 32'd3);
    word = {mem[i3], mem[i2], mem[i1], mem[i0]};

    be = 4'b0000;
    if (access && we_q && !req_err) begin
      case (func3_q[1:0])
        2'd0:    be = 4'b0001;
        2'd1:    be = 4'b0011;
        default: be = 4'b1111;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    func3_d = func3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          func3_d = req_func3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          err_d   = req_err;
          rdata_d = (we_q || req_err) ? 32'd0 : load_ext(func3_q, word);
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      func3_q <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      we_q    <= we_d;
      func3_q <= func3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Storage is deliberately not reset; a reset mid-request suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (be[0]) mem[i0] <= wdata_q[7:0];
      if (be[1]) mem[i1] <= wdata_q[15:8];
      if (be[2]) mem[i2] <= wdata_q[23:16];
      if (be[3]) mem[i3] <= wdata_q[31:24];
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a byte-array reference model predicts every
// response at accept time; a monitor pops and compares whenever resp_valid is seen.
module tb_data_mem_ctrl;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 512;
  localparam int LAT    = 2;
  localparam int MEM_BYTES = 4 * DEPTH;

  logic              clk, rst;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid, resp_err, busy;
  logic [31:0]       resp_rdata;

  data_mem_ctrl #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mref [MEM_BYTES];
  int          errors = 0;
  int          checks = 0;
  int          edges  = 0;
  int          last_acc = 0;
  int          n_push = 0;
  int          n_resp = 0;
  logic [31:0] last_rd = 32'd0;
  logic        last_er = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    edges = edges + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: RV32 load/store rules applied to a plain byte array.
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [11:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int     sz, ai;
    bit     sgn, legal;
    longint v;
    ai = int'(a); sz = 4; sgn = 0; legal = 1;
    case (f3)
      3'd0: begin sz = 1; sgn = 1; end
      3'd1: begin sz = 2; sgn = 1; end
      3'd2: sz = 4;
      3'd4: sz = 1;
      3'd5: sz = 2;
      default: legal = 0;
    endcase
    if (we && f3 > 3'd2) legal = 0;
    er = !legal || (ai % sz != 0) || (ai + sz > MEM_BYTES);
    rd = 32'd0;
    if (!er) begin
      if (we) begin
        for (int k = 0; k < sz; k++) mref[ai + k] = wd[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < sz; k++) v = v + (longint'(mref[ai + k]) << (8 * k));
        if (sgn && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
        rd = 32'(v);
      end
    end
  endtask

  // Called at a negedge; leaves req_valid high afterwards so back-to-back calls stream.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] wd, input bit model_it, input bit chk_gap);
    int          n;
    exp_t        e;
    logic [31:0] rd;
    logic        er;
    req_valid = 1'b1; req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    if (model_it) begin
      model_access(we, f3, a, wd, rd, er);
      e.rd = rd; e.er = er; e.due = edges + 1 + LAT;
      q.push_back(e);
      n_push++;
    end
    if (chk_gap) chk("accept_gap", 32'(edges + 1 - last_acc), 32'(LAT + 2));
    last_acc = edges + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic one(input string name, input logic we, input logic [2:0] f3,
                     input logic [11:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_er);
    issue(we, f3, a, wd, 1'b1, 1'b0);
    drain();
    chk({name, "_rdata"}, last_rd, exp_rd);
    chk({name, "_err"}, 32'(last_er), 32'(exp_er));
  endtask

  // Monitor: compares every response against the head of the scoreboard.
  initial begin
    exp_t e;
    logic prev_rv;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rv = 1'b0;
      end else begin
        if (resp_valid) begin
          if (prev_rv) chk("resp_pulse_width", 32'd2, 32'd1);
          if (q.size() == 0) begin
            chk("spurious_resp", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            n_resp++;
            chk("resp_rdata", resp_rdata, e.rd);
            chk("resp_err", 32'(resp_err), 32'(e.er));
            chk("resp_timing", 32'(edges), 32'(e.due));
          end
          last_rd = resp_rdata;
          last_er = resp_err;
        end
        prev_rv = resp_valid;
      end
    end
  end

  initial begin
    logic [2:0]  f3;
    logic [11:0] a;
    int          r;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0;
    req_addr = '0; req_wdata = 32'd0;
    #2 rst = 1'b1;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int w = 0; w < 64; w++) issue(1'b1, 3'd2, 12'(4 * w), $urandom, 1'b1, w != 0);
    issue(1'b1, 3'd2, 12'h7F8, $urandom, 1'b1, 1'b1);
    issue(1'b1, 3'd2, 12'h7FC, $urandom, 1'b1, 1'b1);
    drain();

    one("sw_010",  1'b1, 3'd2, 12'h010, 32'h80FF_1234, 32'h0000_0000, 1'b0);
    one("lw_010",  1'b0, 3'd2, 12'h010, 32'd0, 32'h80FF_1234, 1'b0);
    one("lb_010",  1'b0, 3'd0, 12'h010, 32'd0, 32'h0000_0034, 1'b0);
    one("lb_013",  1'b0, 3'd0, 12'h013, 32'd0, 32'hFFFF_FF80, 1'b0);
    one("lbu_013", 1'b0, 3'd4, 12'h013, 32'd0, 32'h0000_0080, 1'b0);
    one("lh_012",  1'b0, 3'd1, 12'h012, 32'd0, 32'hFFFF_80FF, 1'b0);
    one("lhu_012", 1'b0, 3'd5, 12'h012, 32'd0, 32'h0000_80FF, 1'b0);
    one("sw_020",  1'b1, 3'd2, 12'h020, 32'h1122_3344, 32'd0, 1'b0);
    one("sb_021",  1'b1, 3'd0, 12'h021, 32'hAAAA_AA5C, 32'd0, 1'b0);
    one("lw_020",  1'b0, 3'd2, 12'h020, 32'd0, 32'h1122_5C44, 1'b0);
    one("sw_030",  1'b1, 3'd2, 12'h030, 32'h5566_7788, 32'd0, 1'b0);
    one("lw_022",  1'b0, 3'd2, 12'h022, 32'd0, 32'd0, 1'b1);
    one("sh_031",  1'b1, 3'd1, 12'h031, 32'hFFFF_FFFF, 32'd0, 1'b1);
    one("lh_005",  1'b0, 3'd1, 12'h005, 32'd0, 32'd0, 1'b1);
    one("lw_030",  1'b0, 3'd2, 12'h030, 32'd0, 32'h5566_7788, 1'b0);
    one("lw_800",  1'b0, 3'd2, 12'h800, 32'd0, 32'd0, 1'b1);
    one("sw_FFE",  1'b1, 3'd2, 12'hFFE, 32'h1234_5678, 32'd0, 1'b1);
    one("ld_f3_3", 1'b0, 3'd3, 12'h010, 32'd0, 32'd0, 1'b1);
    one("st_f3_4", 1'b1, 3'd4, 12'h010, 32'h0, 32'd0, 1'b1);
    one("sw_040",  1'b1, 3'd2, 12'h040, 32'h0BAD_F00D, 32'd0, 1'b0);
    one("lw_010b", 1'b0, 3'd2, 12'h010, 32'd0, 32'h80FF_1234, 1'b0);

    // Reset one cycle after accepting a store: no response, outputs clear at once.
    issue(1'b1, 3'd2, 12'h040, 32'hDEAD_BEEF, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1; req_valid = 1'b0;
    #1;
    chk("wrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("wrst_rdata", resp_rdata, 32'd0);
    chk("wrst_err", 32'(resp_err), 32'd0);
    chk("wrst_busy", 32'(busy), 32'd0);
    chk("wrst_ready", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    one("lw_040",  1'b0, 3'd2, 12'h040, 32'd0, 32'h0BAD_F00D, 1'b0);

    // Continuous random stream with req_valid held high.
    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 279);
      a  = (r < 256) ? 12'(r) : 12'(32'h7F8 + r - 256);
      f3 = 3'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), f3, a, $urandom, 1'b1, i != 0);
    end
    drain();

    chk("resp_count", 32'(n_resp), 32'(n_push));
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
